// File: rtl/aes_pkg.sv
// Shared AES definitions for the AddRoundKey stage: widths, round constants,
// FSM encoding, output slot layout and a GF(2^8) multiply used by the S-box.
package aes_pkg;

  localparam int STATE_W            = 128;
  localparam int WORD_W             = 32;
  localparam int BYTE_W             = 8;
  localparam int NUM_ROUNDS_DEFAULT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ark_fsm_e;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [3:0]         round;
    logic               last;
  } ark_slot_t;

  // Round constant for the key word produced when entering round idx (1..10).
  function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] idx);
    logic [BYTE_W-1:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_add_round_key_if.sv
// Key-load and valid/ready stream bundle for the AddRoundKey stage.
// slave = the stage itself, master = whatever drives it.
interface aes_add_round_key_if;
  import aes_pkg::*;

  logic               key_load;
  logic [STATE_W-1:0] key_in;
  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] state_in;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] state_out;
  logic [3:0]         out_round;
  logic               out_last;

  modport slave (
    input  key_load, key_in, in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, out_round, out_last
  );

  modport master (
    output key_load, key_in, in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, out_round, out_last
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by
// the affine transform, computed rather than tabulated.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout
);

  logic [BYTE_W-1:0] sq;
  logic [BYTE_W-1:0] inv;

  // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0 as required.
  always_comb begin
    sq  = din;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign dout = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;

endmodule

// File: rtl/aes_add_round_key.sv
// AddRoundKey stage with on-the-fly AES-128 key expansion, 1 state/cycle.
// Define AES_ARK_SKID_EN for a 2-entry output skid buffer with registered in_ready.
module aes_add_round_key
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
)
(
  input  logic                clk,
  input  logic                rst,
  aes_add_round_key_if.slave  bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ark_fsm_e           fsm;
  logic [STATE_W-1:0] cipher_key;
  logic [STATE_W-1:0] rk;
  logic [STATE_W-1:0] rk_next;
  logic [3:0]         round;
  logic [3:0]         rcon_idx;
  logic               accept;
  logic               in_ready;
  ark_slot_t          new_slot;

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w3, sub_w3;
  logic [WORD_W-1:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = rk;
  assign rot_w3           = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .din  (rot_w3[BYTE_W*i +: BYTE_W]),
      .dout (sub_w3[BYTE_W*i +: BYTE_W])
    );
  end

  assign rcon_idx = round + 4'd1;
  assign n0       = w0 ^ sub_w3 ^ {rcon(rcon_idx), 24'h000000};
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign rk_next  = {n0, n1, n2, n3};

  assign new_slot = {bus.state_in ^ rk, round, (round == LAST_ROUND)};

  // After the last round the schedule wraps to the cipher key so the next
  // block can follow without a reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      cipher_key <= '0;
      rk         <= '0;
      round      <= '0;
    end else if (bus.key_load) begin
      fsm        <= RUN;
      cipher_key <= bus.key_in;
      rk         <= bus.key_in;
      round      <= '0;
    end else if (accept) begin
      if (round == LAST_ROUND) begin
        rk    <= cipher_key;
        round <= '0;
      end else begin
        rk    <= rk_next;
        round <= round + 4'd1;
      end
    end
  end

`ifdef AES_ARK_SKID_EN

  ark_slot_t  slot0;
  ark_slot_t  slot1;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       pop;
  logic       in_ready_q;

  assign pop        = (count != 2'd0) & bus.out_ready;
  assign accept     = bus.in_valid & in_ready_q & ~bus.key_load;
  assign count_next = count + {1'b0, accept} - {1'b0, pop};
  assign in_ready   = in_ready_q;

  // slot0 is always the head presented downstream; slot1 only fills while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0      <= '0;
      slot1      <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
    end else if (bus.key_load) begin
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count      <= count_next;
      in_ready_q <= (fsm == RUN) && (count_next != 2'd2);
      case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= new_slot;
          else               slot1 <= new_slot;
        end
        2'b01: begin
          if (count == 2'd2) slot0 <= slot1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= new_slot;
          end else begin
            slot0 <= slot1;
            slot1 <= new_slot;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.state_out = slot0.state;
  assign bus.out_round = slot0.round;
  assign bus.out_last  = slot0.last;

`else

  ark_slot_t slot;
  logic      slot_valid;

  assign in_ready = (fsm == RUN) & ~bus.key_load & (~slot_valid | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot       <= '0;
      slot_valid <= 1'b0;
    end else if (bus.key_load) begin
      slot_valid <= 1'b0;
    end else if (accept) begin
      slot       <= new_slot;
      slot_valid <= 1'b1;
    end else if (slot_valid && bus.out_ready) begin
      slot_valid <= 1'b0;
    end
  end

  assign bus.out_valid = slot_valid;
  assign bus.state_out = slot.state;
  assign bus.out_round = slot.round;
  assign bus.out_last  = slot.last;

`endif

  assign bus.in_ready = in_ready;

endmodule

// File: tb/tb_aes_add_round_key.sv
// Directed, table-driven bench for aes_add_round_key using FIPS-197 vectors.
module tb_aes_add_round_key;

  logic clk;
  logic rst;

  aes_add_round_key_if bus ();

  aes_add_round_key dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [127:0] exp;
    logic [3:0]   rnd;
    logic         last;
  } vec_t;

`ifdef AES_ARK_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] rk_tab [11];
  logic [127:0] stall_st [6];
  vec_t         tbl [12];
  int           n_checks;
  int           n_fail;

  task automatic applyStimulus(input logic kl, input logic [127:0] key,
                               input logic iv, input logic [127:0] st,
                               input logic ordy);
    bus.key_load  = kl;
    bus.key_in    = key;
    bus.in_valid  = iv;
    bus.state_in  = st;
    bus.out_ready = ordy;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    logic was_ready;

    n_checks = 0;
    n_fail   = 0;

    rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    for (int i = 0; i < 12; i++) begin
      int r;
      r = (i == 11) ? 0 : i;
      tbl[i].st   = '0;
      if (i == 3) tbl[i].st = '1;
      if (i == 7) tbl[i].st = 128'h0123456789abcdeffedcba9876543210;
      tbl[i].exp  = tbl[i].st ^ rk_tab[r];
      tbl[i].rnd  = 4'(r);
      tbl[i].last = (r == 10);
    end
    tbl[0].st  = 128'h3243f6a8885a308d313198a2e0370734;
    tbl[0].exp = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    for (int k = 0; k < 6; k++) stall_st[k] = {4{32'ha5a50000 + 32'(k)}};

    // Reset state and IDLE behaviour
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_state_out", bus.state_out, 0);
    checkOutput("reset_out_round", bus.out_round, 0);
    checkOutput("reset_out_last",  bus.out_last,  0);
    checkOutput("reset_in_ready",  bus.in_ready,  0);
    applyStimulus(1'b0, '0, 1'b1, '1, 1'b1);
    #1;
    checkOutput("idle_in_ready", bus.in_ready, 0);
    cycle();
    checkOutput("idle_out_valid", bus.out_valid, 0);

    // Table stream: round 0 FIPS vector, rounds 1..10 back-to-back, then wrap
    applyStimulus(1'b1, KEY_A, 1'b0, '0, 1'b1);
    cycle();
    checkOutput("load_out_valid", bus.out_valid, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, KEY_A, 1'b1, tbl[i].st, 1'b1);
      #1;
      checkOutput($sformatf("stream%0d_in_ready", i), bus.in_ready, 1);
      cycle();
      checkOutput($sformatf("stream%0d_out_valid", i), bus.out_valid, 1);
      checkOutput($sformatf("stream%0d_state_out", i), bus.state_out, tbl[i].exp);
      checkOutput($sformatf("stream%0d_out_round", i), bus.out_round, 128'(tbl[i].rnd));
      checkOutput($sformatf("stream%0d_out_last", i),  bus.out_last,  128'(tbl[i].last));
    end
    applyStimulus(1'b0, KEY_A, 1'b0, '0, 1'b1);
    cycle();
    checkOutput("stream_drain_out_valid", bus.out_valid, 0);

    // Downstream stall for 5 cycles with input continuously offered
    applyStimulus(1'b1, KEY_A, 1'b0, '0, 1'b0);
    cycle();
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, KEY_A, 1'b1, stall_st[acc], 1'b0);
      #1;
      was_ready = bus.in_ready;
      cycle();
      if (was_ready) acc++;
      checkOutput($sformatf("stall%0d_out_valid", c), bus.out_valid, 1);
      checkOutput($sformatf("stall%0d_state_out", c), bus.state_out,
                  stall_st[0] ^ rk_tab[0]);
    end
    checkOutput("stall_accept_count", 128'(acc), 128'(EXP_ACC));
    applyStimulus(1'b0, KEY_A, 1'b0, '0, 1'b1);
    for (int j = 0; j < EXP_ACC; j++) begin
      checkOutput($sformatf("release%0d_out_valid", j), bus.out_valid, 1);
      checkOutput($sformatf("release%0d_state_out", j), bus.state_out,
                  stall_st[j] ^ rk_tab[j]);
      checkOutput($sformatf("release%0d_out_round", j), bus.out_round, 128'(j));
      cycle();
    end
    checkOutput("release_empty", bus.out_valid, 0);

    // key_load beats a simultaneous input and output handshake
    applyStimulus(1'b0, KEY_A, 1'b1, '1, 1'b0);
    cycle();
    checkOutput("preload_out_valid", bus.out_valid, 1);
    applyStimulus(1'b1, KEY_B, 1'b1, '1, 1'b1);
    cycle();
    checkOutput("reload_flush_out_valid", bus.out_valid, 0);
    applyStimulus(1'b0, KEY_B, 1'b1, '0, 1'b1);
    cycle();
    checkOutput("reload_state_out", bus.state_out, KEY_B);
    checkOutput("reload_out_round", bus.out_round, 0);
    checkOutput("reload_out_valid", bus.out_valid, 1);
    for (int r = 1; r <= 5; r++) begin
      applyStimulus(1'b0, KEY_B, 1'b1, '0, 1'b1);
      cycle();
      checkOutput($sformatf("keyb_round%0d", r), bus.out_round, 128'(r));
    end

    // Reset in the middle of a block
    rst = 1'b1;
    applyStimulus(1'b0, KEY_B, 1'b0, '0, 1'b1);
    cycle();
    rst = 1'b0;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_state_out", bus.state_out, 0);
    checkOutput("midrst_out_round", bus.out_round, 0);
    checkOutput("midrst_out_last",  bus.out_last,  0);
    applyStimulus(1'b0, KEY_B, 1'b1, '1, 1'b1);
    #1;
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    cycle();
    checkOutput("midrst_no_accept", bus.out_valid, 0);
    applyStimulus(1'b1, KEY_A, 1'b0, '0, 1'b1);
    cycle();
    applyStimulus(1'b0, KEY_A, 1'b1, tbl[0].st, 1'b1);
    cycle();
    checkOutput("relaunch_state_out", bus.state_out, tbl[0].exp);
    checkOutput("relaunch_out_round", bus.out_round, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
